// File: rtl/prt_div_scheduler_pkg.sv
// Shared types and constants for the plane_ray divide scheduler.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package plane_ray_int_defines;

    // Scheduler control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } div_sched_state_t;

    // Operand pair presented by one requester
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } div_req_t;

    // Default credit limit: divisions allowed inside the divider at once
    localparam int DEF_MAX_OUTSTANDING = 4;

    // Saturating increment for the 16-bit performance counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/prt_div_scheduler_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is actually issued.
module prt_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan NUM_REQ positions starting at the pointer, stop at the first hit
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
                o_any = 1'b1;
                o_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/prt_div_scheduler.sv
// Shares one FP32 divider among NUM_REQ requesters (round-robin, credit-limited), routes results back by tag.
// Latency: issue is combinational in the request cycle; response appears 1 cycle after divider output.
// Backpressure: issue waits for div_ready_i and a free credit; responses are never backpressured. Optional PRT_DIV_SCHED_PERF_EN adds perf counters.
module prt_div_scheduler
    import plane_ray_int_defines::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int TAG_W           = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*32-1:0]  req_a_i,
    input  logic [NUM_REQ*32-1:0]  req_b_i,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    output logic [31:0]            resp_data_o,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic                   div_valid_o,
    input  logic                   div_ready_i,
    output logic [31:0]            div_a_o,
    output logic [31:0]            div_b_o,
    output logic [TAG_W-1:0]       div_tag_o,
    input  logic                   div_valid_i,
    input  logic [31:0]            div_result_i,
    input  logic [TAG_W-1:0]       div_tag_i
`ifdef PRT_DIV_SCHED_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]  perf_grants_o,
    output logic [15:0]            perf_stall_o
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    div_sched_state_t    r_state;
    logic [TAG_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_outstanding;
    logic [NUM_REQ-1:0]  r_resp_valid;
    logic [31:0]         r_resp_data;
    logic                r_flush_done;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [TAG_W-1:0]    w_idx;
    logic                w_any;
    logic                w_credit_ok;
    logic                w_issue;
    div_req_t            w_req [NUM_REQ];
    div_req_t            w_sel;

    prt_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (TAG_W)
    ) u_arb (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Unpack the flat operand buses into per-requester operand pairs
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_req[k].a = req_a_i[k*32 +: 32];
            w_req[k].b = req_b_i[k*32 +: 32];
        end
    end

    assign w_sel       = w_req[w_idx];
    assign w_credit_ok = (r_outstanding < CNT_W'(MAX_OUTSTANDING));
    // Credit uses only registered state, so div_valid_i never reaches req_ready_o.
    // rst_n gating keeps every output at 0 while reset is held.
    assign w_issue     = rst_n && (r_state != DRAIN) && !flush_i && w_any
                         && div_ready_i && w_credit_ok;

    assign req_ready_o  = w_issue ? w_gnt : '0;
    assign div_valid_o  = w_issue;
    assign div_a_o      = w_issue ? w_sel.a : '0;
    assign div_b_o      = w_issue ? w_sel.b : '0;
    assign div_tag_o    = w_issue ? w_idx : '0;
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;
    assign flush_done_o = r_flush_done;

    // Control FSM: flush wins over everything, drain ends once nothing is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (flush_i) begin
                        r_state <= DRAIN;
                    end else if (|req_valid_i) begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush_i) begin
                        r_state <= DRAIN;
                    end else if (!(|req_valid_i) && (r_outstanding == '0)) begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state      <= IDLE;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Round-robin pointer moves past the winner only when something is issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            if (int'(w_idx) == NUM_REQ - 1) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_idx + TAG_W'(1);
            end
        end
    end

    // In-flight count: +1 per issue, -1 per divider result, simultaneous events cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            case ({w_issue, div_valid_i})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01: begin
                    if (r_outstanding != '0) begin
                        r_outstanding <= r_outstanding - CNT_W'(1);
                    end
                end
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // A result with no division in flight, or an issue beyond the credit limit, is a protocol bug
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(div_valid_i && !w_issue && (r_outstanding == '0)));
            assert (!(w_issue && !div_valid_i && (r_outstanding >= CNT_W'(MAX_OUTSTANDING))));
        end
    end

    // Register the divider result and steer it to the requester named by its tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            // Out-of-range tags are dropped here; the credit is still returned above
            if (div_valid_i && (int'(div_tag_i) < NUM_REQ)) begin
                r_resp_valid[div_tag_i] <= 1'b1;
                r_resp_data             <= div_result_i;
            end
        end
    end

`ifdef PRT_DIV_SCHED_PERF_EN
    logic [15:0] r_perf_grants [NUM_REQ];
    logic [15:0] r_perf_stall;
    logic        w_stall;

    // A waiting request that is held back only by credit or divider readiness
    assign w_stall = rst_n && (r_state != DRAIN) && !flush_i && (|req_valid_i)
                     && !(div_ready_i && w_credit_ok);

    // Saturating per-requester grant counters and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                r_perf_grants[k] <= '0;
            end
            r_perf_stall <= '0;
        end else begin
            if (w_issue) begin
                r_perf_grants[w_idx] <= sat_inc16(r_perf_grants[w_idx]);
            end
            if (w_stall) begin
                r_perf_stall <= sat_inc16(r_perf_stall);
            end
        end
    end

    // Flatten the grant counters onto the output bus
    always_comb begin
        perf_grants_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            perf_grants_o[k*16 +: 16] = r_perf_grants[k];
        end
    end

    assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_prt_div_scheduler.sv
`timescale 1ns/1ps
module tb_prt_div_scheduler;

    localparam int NUM_REQ = 4;
    localparam int MAXO    = 4;
    localparam int TAG_W   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*32-1:0] req_a_i;
    logic [NUM_REQ*32-1:0] req_b_i;
    logic [NUM_REQ-1:0]    resp_valid_o;
    logic [31:0]           resp_data_o;
    logic                  flush_i;
    logic                  flush_done_o;
    logic                  div_valid_o;
    logic                  div_ready_i;
    logic [31:0]           div_a_o;
    logic [31:0]           div_b_o;
    logic [TAG_W-1:0]      div_tag_o;
    logic                  div_valid_i;
    logic [31:0]           div_result_i;
    logic [TAG_W-1:0]      div_tag_i;

    always #5 clk = ~clk;

    prt_div_scheduler #(
        .NUM_REQ         (NUM_REQ),
        .MAX_OUTSTANDING (MAXO),
        .TAG_W           (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .div_valid_o  (div_valid_o),
        .div_ready_i  (div_ready_i),
        .div_a_o      (div_a_o),
        .div_b_o      (div_b_o),
        .div_tag_o    (div_tag_o),
        .div_valid_i  (div_valid_i),
        .div_result_i (div_result_i),
        .div_tag_i    (div_tag_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Requester side: each requester holds its operands until it is granted
    logic        m_rv [NUM_REQ];
    logic [31:0] m_ra [NUM_REQ];
    logic [31:0] m_rb [NUM_REQ];
    // Scheduler reference: pointer, credits in use, drain mode, pending done pulse
    int          m_ptr;
    int          m_cnt;
    bit          m_drain;
    bit          m_done_next;

    typedef struct { int tag; logic [31:0] res; int due; } div_ent_t;
    typedef struct { logic [NUM_REQ-1:0] vld; logic [31:0] dat; int cyc; } resp_t;
    div_ent_t div_q [$];
    resp_t    sb_q  [$];

    int p_new, p_rdy, lat, p_ostall;
    bit force_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pow2f(input bit s, input int e);
        return {s, 8'(e), 23'd0};
    endfunction

    // Quotient of two exact powers of two: exponents subtract, sign is the xor
    function automatic logic [31:0] fdiv_pow2(input logic [31:0] a, input logic [31:0] b);
        int e;
        e = int'(a[30:23]) - int'(b[30:23]) + 127;
        return {a[31] ^ b[31], 8'(e), 23'd0};
    endfunction

    function automatic bit any_rv();
        bit r;
        r = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) r = r | m_rv[k];
        return r;
    endfunction

    task automatic new_req(input int r);
        m_rv[r] = ($urandom_range(99) < p_new);
        m_ra[r] = pow2f(1'($urandom_range(1)), int'($urandom_range(145, 110)));
        m_rb[r] = pow2f(1'($urandom_range(1)), int'($urandom_range(145, 110)));
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < NUM_REQ; r++) begin
            req_valid_i[r]        = m_rv[r];
            req_a_i[r*32 +: 32]   = m_ra[r];
            req_b_i[r*32 +: 32]   = m_rb[r];
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready_o),  64'(0));
        chk({tag, "_div_valid"},  64'(div_valid_o),  64'(0));
        chk({tag, "_div_a"},      64'(div_a_o),      64'(0));
        chk({tag, "_div_b"},      64'(div_b_o),      64'(0));
        chk({tag, "_div_tag"},    64'(div_tag_o),    64'(0));
        chk({tag, "_resp_valid"}, 64'(resp_valid_o), 64'(0));
        chk({tag, "_resp_data"},  64'(resp_data_o),  64'(0));
        chk({tag, "_flush_done"}, 64'(flush_done_o), 64'(0));
    endtask

    // One clock cycle: drive stimulus, compare issue-side outputs, advance the reference
    task automatic step(input bit fl);
        int                 g;
        bit                 exp_issue;
        bit                 ret;
        logic [NUM_REQ-1:0] exp_rdy;
        div_ent_t           e;
        resp_t              s;
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < NUM_REQ; r++) if (!m_rv[r]) new_req(r);
        drive_reqs();
        div_ready_i = ($urandom_range(99) < p_rdy);
        flush_i     = fl;
        ret = (div_q.size() > 0) && !force_stall && ($urandom_range(99) >= p_ostall);
        if (ret) ret = (div_q[0].due <= cyc);
        if (ret) begin
            e            = div_q.pop_front();
            div_valid_i  = 1'b1;
            div_result_i = e.res;
            div_tag_i    = TAG_W'(e.tag);
        end else begin
            div_valid_i  = 1'b0;
            div_result_i = $urandom;
            div_tag_i    = TAG_W'($urandom_range(NUM_REQ - 1));
        end
        #3;
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (g < 0 && m_rv[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        end
        exp_issue = (g >= 0) && !m_drain && !fl && div_ready_i && (m_cnt < MAXO);
        exp_rdy = '0;
        if (exp_issue) exp_rdy[g] = 1'b1;
        chk("req_ready",  64'(req_ready_o),  64'(exp_rdy));
        chk("div_valid",  64'(div_valid_o),  64'(exp_issue));
        chk("flush_done", 64'(flush_done_o), 64'(m_done_next));
        if (exp_issue) begin
            chk("div_a",   64'(div_a_o),   64'(m_ra[g]));
            chk("div_b",   64'(div_b_o),   64'(m_rb[g]));
            chk("div_tag", 64'(div_tag_o), 64'(g));
        end
        // Advance the reference to the next cycle
        m_done_next = 1'b0;
        if (m_drain) begin
            if (m_cnt == 0) begin
                m_drain     = 1'b0;
                m_done_next = 1'b1;
            end
        end else if (fl) begin
            m_drain = 1'b1;
        end
        m_cnt = m_cnt + (exp_issue ? 1 : 0) - (ret ? 1 : 0);
        if (exp_issue) begin
            div_q.push_back('{tag: g, res: fdiv_pow2(m_ra[g], m_rb[g]), due: cyc + lat});
            m_ptr   = (g + 1) % NUM_REQ;
            m_rv[g] = 1'b0;
        end
        if (ret) begin
            s.vld        = '0;
            s.vld[e.tag] = 1'b1;
            s.dat        = e.res;
            s.cyc        = cyc + 1;
            sb_q.push_back(s);
        end
    endtask

    task automatic reset_model();
        m_ptr = 0; m_cnt = 0; m_drain = 1'b0; m_done_next = 1'b0;
        div_q.delete();
        sb_q.delete();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        p_new = 0; p_rdy = 100; p_ostall = 0; force_stall = 1'b0;
        while ((m_cnt != 0 || sb_q.size() != 0 || any_rv() || m_drain || m_done_next) && n < budget) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: outstanding %0d pending %0d after %0d cycles", m_cnt, sb_q.size(), n);
        end
    endtask

    // Assert reset between clock edges while traffic is being issued
    task automatic mid_reset();
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < NUM_REQ; r++) m_rv[r] = 1'b1;
        drive_reqs();
        div_ready_i = 1'b1; flush_i = 1'b0; div_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        reset_model();
        req_valid_i = '0; div_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response monitor: every presented response must match the oldest expected one
    initial begin : monitor
        resp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) continue;
            if (resp_valid_o != '0) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid_o), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_valid", 64'(resp_valid_o), 64'(e.vld));
                    chk("resp_data",  64'(resp_data_o),  64'(e.dat));
                    chk("resp_cycle", 64'(cyc),          64'(e.cyc));
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                chk("resp_missing", 64'(resp_valid_o), 64'(e.vld));
            end
        end
    end

    initial begin : stim
        req_valid_i = '1; req_a_i = '1; req_b_i = '1;
        div_ready_i = 1'b1; flush_i = 1'b0;
        div_valid_i = 1'b0; div_result_i = '0; div_tag_i = '0;
        p_new = 0; p_rdy = 100; lat = 3; p_ostall = 0; force_stall = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin m_rv[r] = 1'b0; m_ra[r] = '0; m_rb[r] = '0; end
        reset_model();
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        req_valid_i = '0; div_ready_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 1: 4.0 / 2.0 with a 3-cycle divider
        m_rv[1] = 1'b1; m_ra[1] = 32'h40800000; m_rb[1] = 32'h40000000;
        repeat (8) step(1'b0);

        // All requesters continuously valid, divider always ready
        p_new = 100; lat = 2;
        repeat (24) step(1'b0);
        drain(200);

        // Divider outputs stalled: credit limit blocks issue, release resumes it
        p_new = 100; lat = 1; force_stall = 1'b1;
        repeat (10) step(1'b0);
        force_stall = 1'b0;
        repeat (20) step(1'b0);
        drain(200);

        // Flush with three divisions in flight
        p_new = 100; lat = 2; force_stall = 1'b1;
        repeat (3) step(1'b0);
        step(1'b1);
        force_stall = 1'b0;
        repeat (15) step(1'b0);
        drain(200);

        // Randomized traffic, with an asynchronous reset in the middle
        for (int blk = 0; blk < 8; blk++) begin
            p_new    = int'($urandom_range(100, 20));
            p_rdy    = int'($urandom_range(100, 30));
            lat      = int'($urandom_range(6, 1));
            p_ostall = int'($urandom_range(60, 0));
            for (int i = 0; i < 100; i++) step($urandom_range(99) < 2);
            if (blk == 3) begin
                mid_reset();
                p_new = 100; p_rdy = 100; lat = 1; force_stall = 1'b1;
                repeat (8) step(1'b0);
                force_stall = 1'b0;
            end
        end
        drain(300);
        step(1'b0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
